fetch_stage: RTL and testbench

//  Instruction fetch stage; sits directly upstream of decode/immediate generation.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_stage.sv | 109 ++++++++++
 tb/tb_fetch_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage defaults and the {pc, insn} packet handed to decode.
package fetch_pkg;

    localparam int DEF_AWIDTH = 32;
    localparam int DEF_DWIDTH = 32;
    localparam int DEF_DEPTH  = 2;
    localparam logic [DEF_AWIDTH-1:0] DEF_BASEADDR = 32'h0100_0000;

    typedef struct packed {
        logic [DEF_AWIDTH-1:0] pc;
        logic [DEF_DWIDTH-1:0] insn;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; push while full is accepted
// when a pop happens in the same cycle. DEPTH must be a power of two, >= 2.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign head    = mem[rd_ptr];

    // Storage is cleared only on reset so the head reads zero afterwards; flush just rewinds.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited memory requests, pairs
// in-order responses with their PC for decode, and squashes fetches on redirect.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                AWIDTH   = DEF_AWIDTH,
    parameter int                DWIDTH   = DEF_DWIDTH,
    parameter logic [AWIDTH-1:0] BASEADDR = DEF_BASEADDR,
    parameter int                DEPTH    = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [AWIDTH-1:0] dec_pc_o,
    output logic [DWIDTH-1:0] dec_insn_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t          DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(DEPTH);

    logic [AWIDTH-1:0]        pc_q;
    cnt_t                     inflight;
    cnt_t                     drop_cnt;
    cnt_t                     out_count;
    cnt_t                     pc_count;
    logic [AWIDTH-1:0]        pc_head;
    logic [AWIDTH+DWIDTH-1:0] out_head;
    logic [CW:0]              occupancy;
    logic                     req_fire;
    logic                     rsp_keep;
    logic                     dec_fire;
    logic [1:0]               unused_redirect_lsbs;

    // Both ports transfer on a cycle where valid && ready; valid never waits on ready.
    assign dec_valid_o = (out_count != '0);
    assign dec_fire    = dec_valid_o && dec_ready_i && !redirect_i;
    assign dec_pc_o    = out_head[AWIDTH+DWIDTH-1 -: AWIDTH];
    assign dec_insn_o  = out_head[DWIDTH-1:0];

    // A decode pop this cycle frees its slot, so a 1-cycle memory streams at full rate.
    assign occupancy        = {1'b0, inflight} + {1'b0, out_count} - (CW+1)'(dec_fire);
    assign imem_req_valid_o = !reset && !redirect_i && (occupancy < DEPTH_OCC);
    assign imem_addr_o      = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign rsp_keep         = imem_rsp_valid_i && !redirect_i && (drop_cnt == '0);

    assign unused_redirect_lsbs = redirect_pc_i[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= BASEADDR;
            inflight <= '0;
            drop_cnt <= '0;
        end else if (redirect_i) begin
            // Everything still outstanding after this cycle targets the old path.
            pc_q     <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
            inflight <= inflight - cnt_t'(imem_rsp_valid_i);
            drop_cnt <= inflight - cnt_t'(imem_rsp_valid_i);
        end else begin
            if (req_fire) begin
                pc_q <= pc_q + AWIDTH'(4);
            end
            inflight <= inflight + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid_i);
            if (imem_rsp_valid_i && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - cnt_t'(1);
            end
        end
    end

    fetch_fifo #(.WIDTH(AWIDTH), .DEPTH(DEPTH)) u_pc_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (imem_rsp_valid_i),
        .head      (pc_head),
        .count     (pc_count)
    );

    fetch_fifo #(.WIDTH(AWIDTH + DWIDTH), .DEPTH(DEPTH)) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_i),
        .push      (rsp_keep),
        .push_data ({pc_head, imem_rsp_data_i}),
        .pop       (dec_fire),
        .head      (out_head),
        .count     (out_count)
    );

    a_inflight_bound : assert property (@(posedge clk) disable iff (reset) inflight <= DEPTH_CNT);
    a_drop_bound     : assert property (@(posedge clk) disable iff (reset) drop_cnt <= DEPTH_CNT);
    a_out_bound      : assert property (@(posedge clk) disable iff (reset) out_count <= DEPTH_CNT);
    a_pc_tracking    : assert property (@(posedge clk) disable iff (reset) pc_count == inflight);
    a_rsp_credit     : assert property (@(posedge clk) disable iff (reset)
                                        imem_rsp_valid_i |-> (inflight != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model, fetch/packet queues as the reference,
// directed scenarios with literal checks, then a randomized run.
`timescale 1ns/1ps
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam logic [31:0] KEY   = 32'h5EED_C0DE;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        dec_valid_o;
    logic        dec_ready_i = 1'b0;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_insn_o;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .dec_valid_o      (dec_valid_o),
        .dec_ready_i      (dec_ready_i),
        .dec_pc_o         (dec_pc_o),
        .dec_insn_o       (dec_insn_o)
    );

    // Stimulus policy, written by the directed sequence, consumed by the cycle driver.
    int          p_req_ready = 100;
    int          p_dec_ready = 100;
    int          p_rsp = 100;
    int          max_lat = 1;
    logic        toggle_ready = 1'b0;
    logic        rst_ctl = 1'b1;
    logic        redir_ctl = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        rand_redir = 1'b0;
    logic        rand_rst = 1'b0;
    logic        redir_coinc = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference: next fetch PC, outstanding fetches (stale after a redirect), decode buffer.
    logic [31:0] m_pc = BASE;
    logic [31:0] fly_pc[$];
    logic        fly_stale[$];
    logic [63:0] exp_q[$];

    logic [31:0] mem_addr[$];
    int          mem_due[$];

    logic [31:0] dec_pcs[$];
    logic [31:0] dec_insns[$];
    int          dec_cycs[$];
    logic [31:0] req_addrs[$];
    int          req_cycs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic       e_req;
        logic       e_dec;
        logic       pop;
        logic       stale;
        logic [31:0] p;
        int         d;
        fetch_pkt_t h;

        cyc++;
        reset            = rst_ctl || (rand_rst && ($urandom_range(0, 399) == 0));
        imem_req_ready_i = toggle_ready ? cyc[0] : ($urandom_range(0, 99) < p_req_ready);
        dec_ready_i      = ($urandom_range(0, 99) < p_dec_ready);
        redirect_i       = !reset && (redir_ctl || (rand_redir && ($urandom_range(0, 99) < 4)));
        redirect_pc_i    = redir_ctl ? redir_pc : $urandom();
        redir_ctl        = 1'b0;
        if (!reset && (mem_addr.size() > 0) && (mem_due[0] <= cyc) && ($urandom_range(0, 99) < p_rsp)) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_addr[0] ^ KEY;
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = $urandom();
        end

        #1;
        e_dec = (exp_q.size() > 0);
        pop   = e_dec && dec_ready_i && !redirect_i;
        e_req = !reset && !redirect_i && ((fly_pc.size() + exp_q.size() - (pop ? 1 : 0)) < DEPTH);
        check("req_valid", 64'(imem_req_valid_o), 64'(e_req));
        check("addr", 64'(imem_addr_o), 64'(m_pc));
        check("dec_valid", 64'(dec_valid_o), 64'(e_dec));
        if (e_dec) begin
            h = exp_q[0];
            check("dec_pc", 64'(dec_pc_o), 64'(h.pc));
            check("dec_insn", 64'(dec_insn_o), 64'(h.insn));
        end

        if (imem_req_valid_o && imem_req_ready_i) begin
            req_addrs.push_back(imem_addr_o);
            req_cycs.push_back(cyc);
        end
        if (dec_valid_o && dec_ready_i && !redirect_i && !reset) begin
            dec_pcs.push_back(dec_pc_o);
            dec_insns.push_back(dec_insn_o);
            dec_cycs.push_back(cyc);
        end
        if (redirect_i) begin
            redir_coinc = imem_rsp_valid_i && dec_valid_o && dec_ready_i;
        end

        if (reset) begin
            m_pc = BASE;
            fly_pc.delete();
            fly_stale.delete();
            exp_q.delete();
            mem_addr.delete();
            mem_due.delete();
        end else begin
            if (redirect_i) begin
                exp_q.delete();
                if (imem_rsp_valid_i && (fly_pc.size() > 0)) begin
                    p = fly_pc.pop_front();
                    stale = fly_stale.pop_front();
                end
                foreach (fly_stale[i]) fly_stale[i] = 1'b1;
                m_pc = {redirect_pc_i[31:2], 2'b00};
            end else begin
                if (pop) exp_q.delete(0);
                if (imem_rsp_valid_i && (fly_pc.size() > 0)) begin
                    p = fly_pc.pop_front();
                    stale = fly_stale.pop_front();
                    if (!stale) exp_q.push_back({p, p ^ KEY});
                end
                if (e_req && imem_req_ready_i) begin
                    fly_pc.push_back(m_pc);
                    fly_stale.push_back(1'b0);
                    m_pc = m_pc + 32'd4;
                end
            end
            if (imem_rsp_valid_i) begin
                p = mem_addr.pop_front();
                d = mem_due.pop_front();
            end
            if (imem_req_valid_o && imem_req_ready_i) begin
                mem_addr.push_back(imem_addr_o);
                mem_due.push_back(cyc + int'($urandom_range(1, max_lat)));
            end
        end
    end

    task automatic do_redirect(input logic [31:0] target);
        redir_pc  = target;
        redir_ctl = 1'b1;
        for (int i = 0; i < 10 && redir_ctl; i++) @(posedge clk);
        check("redirect_taken", 64'(redir_ctl), 64'(0));
    endtask

    initial begin
        int n;
        int r;
        int errs;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #2;
        check("rst_req_valid", 64'(imem_req_valid_o), 64'(0));
        check("rst_addr", 64'(imem_addr_o), 64'(32'h0100_0000));
        check("rst_dec_valid", 64'(dec_valid_o), 64'(0));
        check("rst_dec_pc", 64'(dec_pc_o), 64'(0));
        check("rst_dec_insn", 64'(dec_insn_o), 64'(0));

        // Streaming with a ready memory answering in one cycle.
        r = req_addrs.size();
        rst_ctl = 1'b0;
        for (int i = 0; i < 50 && dec_pcs.size() < 3; i++) @(posedge clk);
        check("t1_got3", 64'(dec_pcs.size() >= 3), 64'(1));
        if (dec_pcs.size() >= 3) begin
            check("t1_first_addr", 64'(req_addrs[r]), 64'(32'h0100_0000));
            check("t1_pc0", 64'(dec_pcs[0]), 64'(32'h0100_0000));
            check("t1_pc1", 64'(dec_pcs[1]), 64'(32'h0100_0004));
            check("t1_pc2", 64'(dec_pcs[2]), 64'(32'h0100_0008));
            check("t1_insn0", 64'(dec_insns[0]), 64'(32'h5FED_C0DE));
            check("t1_latency", 64'(dec_cycs[0] - req_cycs[r]), 64'(2));
            check("t1_back2back1", 64'(dec_cycs[1] - dec_cycs[0]), 64'(1));
            check("t1_back2back2", 64'(dec_cycs[2] - dec_cycs[0]), 64'(2));
        end

        // Decode stalls; fetch must stop after filling the credit window.
        repeat (5) @(posedge clk);
        p_dec_ready = 0;
        r = req_addrs.size();
        repeat (6) @(posedge clk);
        #2;
        check("t2_issued_le_depth", 64'((req_addrs.size() - r) <= DEPTH), 64'(1));
        check("t2_req_dropped", 64'(imem_req_valid_o), 64'(0));
        check("t2_holding", 64'(dec_valid_o), 64'(1));
        p_dec_ready = 100;
        repeat (10) @(posedge clk);

        // Memory ready toggling.
        toggle_ready = 1'b1;
        repeat (20) @(posedge clk);
        toggle_ready = 1'b0;
        repeat (6) @(posedge clk);
        errs = 0;
        for (int i = 1; i < dec_pcs.size(); i++) if (dec_pcs[i] != dec_pcs[i-1] + 32'd4) errs++;
        for (int i = 1; i < req_addrs.size(); i++) if (req_addrs[i] != req_addrs[i-1] + 32'd4) errs++;
        check("t123_contiguous", 64'(errs), 64'(0));
        check("t123_progress", 64'(dec_pcs.size() > 20), 64'(1));

        // Redirect with two fetches outstanding.
        p_rsp = 0;
        for (int i = 0; i < 50 && !(fly_pc.size() == 2 && exp_q.size() == 0); i++) @(posedge clk);
        check("t4_two_in_flight", 64'(fly_pc.size() == 2 && exp_q.size() == 0), 64'(1));
        n = dec_pcs.size();
        do_redirect(32'h0100_0100);
        p_rsp = 100;
        for (int i = 0; i < 50 && dec_pcs.size() <= n; i++) @(posedge clk);
        check("t4_got", 64'(dec_pcs.size() > n), 64'(1));
        if (dec_pcs.size() > n) begin
            check("t4_pc", 64'(dec_pcs[n]), 64'(32'h0100_0100));
            check("t4_insn", 64'(dec_insns[n]), 64'(32'h5FED_C1DE));
        end

        // Redirect colliding with a response and a decode pop.
        repeat (8) @(posedge clk);
        n = dec_pcs.size();
        do_redirect(32'h0100_0103);
        #2;
        check("t5_coincident", 64'(redir_coinc), 64'(1));
        check("t5_flushed", 64'(dec_valid_o), 64'(0));
        check("t5_addr", 64'(imem_addr_o), 64'(32'h0100_0100));
        for (int i = 0; i < 50 && dec_pcs.size() <= n; i++) @(posedge clk);
        check("t5_got", 64'(dec_pcs.size() > n), 64'(1));
        if (dec_pcs.size() > n) check("t5_pc", 64'(dec_pcs[n]), 64'(32'h0100_0100));

        // Reset with the decode buffer full.
        p_dec_ready = 0;
        for (int i = 0; i < 50 && exp_q.size() != DEPTH; i++) @(posedge clk);
        check("t6_full", 64'(exp_q.size()), 64'(DEPTH));
        rst_ctl = 1'b1;
        @(posedge clk);
        #2;
        check("t6_dec_valid", 64'(dec_valid_o), 64'(0));
        check("t6_addr", 64'(imem_addr_o), 64'(32'h0100_0000));
        rst_ctl = 1'b0;
        p_dec_ready = 100;
        repeat (5) @(posedge clk);

        // PC wrap at the top of the address space.
        do_redirect(32'hFFFF_FFFC);
        r = req_addrs.size();
        n = dec_pcs.size();
        for (int i = 0; i < 50 && dec_pcs.size() < n + 2; i++) @(posedge clk);
        check("t7_got", 64'(dec_pcs.size() >= n + 2 && req_addrs.size() >= r + 2), 64'(1));
        if (dec_pcs.size() >= n + 2 && req_addrs.size() >= r + 2) begin
            check("t7_req0", 64'(req_addrs[r]), 64'(32'hFFFF_FFFC));
            check("t7_req1", 64'(req_addrs[r+1]), 64'(32'h0000_0000));
            check("t7_dec0", 64'(dec_pcs[n]), 64'(32'hFFFF_FFFC));
            check("t7_dec1", 64'(dec_pcs[n+1]), 64'(32'h0000_0000));
        end

        // Randomized traffic with redirects, occasional resets and variable latency.
        max_lat = 3;
        rand_redir = 1'b1;
        rand_rst = 1'b1;
        for (int k = 0; k < 15; k++) begin
            p_req_ready  = int'($urandom_range(20, 100));
            p_dec_ready  = int'($urandom_range(20, 100));
            p_rsp        = int'($urandom_range(30, 100));
            toggle_ready = ($urandom_range(0, 3) == 0);
            repeat (200) @(posedge clk);
        end
        rand_redir = 1'b0;
        rand_rst = 1'b0;
        toggle_ready = 1'b0;
        p_req_ready = 100;
        p_dec_ready = 100;
        p_rsp = 100;
        repeat (30) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
